// File: rtl/attn_ctrl_pkg.sv
// attn_ctrl_pkg: shared state encoding and run-length helper for the attention scheduler
package attn_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DONE} state_t;
  function automatic int run_cycles(int n, int k);
    return 4 * n + 2 + k;
  endfunction
endpackage

// File: rtl/attn_sched_if.sv
// attn_sched_if: host-side job handshake plus array control outputs of the scheduler
interface attn_sched_if import attn_ctrl_pkg::*; #(parameter int N = 4, parameter int K = 4);
  localparam int CW = $clog2(run_cycles(N, K) + 1);
  logic start_valid, start_ready, reload_weights, abort;
  logic weight_load_enable, do_process, qk_cap, exp_cap, out_cap, result_valid, busy;
  logic [CW-1:0] cycle_cnt;
  logic [N-1:0] q_lane_en;
  logic [15:0] jobs_done;
  modport master (
    output start_valid, reload_weights, abort,
    input start_ready, weight_load_enable, do_process, cycle_cnt, q_lane_en,
    input qk_cap, exp_cap, out_cap, result_valid, busy, jobs_done
  );
  modport slave (
    input start_valid, reload_weights, abort,
    output start_ready, weight_load_enable, do_process, cycle_cnt, q_lane_en,
    output qk_cap, exp_cap, out_cap, result_valid, busy, jobs_done
  );
endinterface

// File: rtl/attn_cycle_counter.sv
// attn_cycle_counter: clearable up-counter flagging when it reaches a programmable last value
module attn_cycle_counter #(parameter int W = 5) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);
  // count up while enabled, restart from zero on clear
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  assign tc = count == last;
endmodule

// File: rtl/attn_sched.sv
// attn_sched: sequences weight load, systolic run and completion for one attention job
module attn_sched import attn_ctrl_pkg::*; #(
  parameter int N = 4,
  parameter int K = 4,
  parameter int WLOAD_CYCLES = 3
) (
  input logic clk,
  input logic reset,
  attn_sched_if.slave bus
);
  localparam int RC = run_cycles(N, K);
  localparam int CW = $clog2(RC + 1);
  localparam int TW = $clog2((RC > WLOAD_CYCLES ? RC : WLOAD_CYCLES) + 1);
  state_t state, nxt;
  logic loaded, hs, tc, run;
  logic [15:0] jobs_q;
  logic [TW-1:0] cnt, last;
  int c;
  assign bus.start_ready = state == IDLE && !bus.abort;
  assign hs = bus.start_valid && bus.start_ready;
  assign run = state == RUN;
  assign last = state == LOAD_W ? TW'(WLOAD_CYCLES - 1) : TW'(RC);
  // one counter times both the weight load and the run; it restarts on every state change
  attn_cycle_counter #(.W(TW)) u_cnt (
    .clk(clk), .reset(reset), .clear(nxt != state || state == IDLE), .enable(1'b1),
    .last(last), .count(cnt), .tc(tc)
  );
  // state, weights-resident flag and completed-job counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      loaded <= 1'b0;
      jobs_q <= '0;
    end else begin
      state <= nxt;
      loaded <= state == LOAD_W ? nxt == RUN : loaded;
      jobs_q <= jobs_q + 16'(nxt == DONE);
    end
  // next state: abort wins everywhere except idle, otherwise advance on terminal count
  always_comb begin
    nxt = state;
    if (state != IDLE && bus.abort) nxt = IDLE;
    else if (state == IDLE) nxt = hs ? ((bus.reload_weights || !loaded) ? LOAD_W : RUN) : IDLE;
    else nxt = state == LOAD_W ? (tc ? RUN : LOAD_W) : run ? (tc ? DONE : RUN) : IDLE;
  end
  // array controls and capture windows decoded from the registered state and count
  always_comb begin
    c = int'(cnt);
    bus.weight_load_enable = state == LOAD_W;
    bus.do_process = run;
    bus.result_valid = state == DONE;
    bus.busy = state != IDLE;
    bus.jobs_done = jobs_q;
    bus.cycle_cnt = run ? CW'(cnt) : '0;
    bus.qk_cap = run && c >= N + 1 && c <= 3 * N - 1;
    bus.exp_cap = run && c >= N + 1 + K && c <= 3 * N - 1 + K;
    bus.out_cap = run && c >= 2 * N + 2 + K && c <= 4 * N + K;
    bus.q_lane_en = '0;
    for (int j = 0; j < N; j++) bus.q_lane_en[j] = run && c >= j && c < j + N;
  end
endmodule

// File: tb/tb_attn_sched.sv
// tb_attn_sched: directed and randomized job sequences checked against a timeline model
module tb_attn_sched;
  localparam int N = 4, K = 4, WL = 3, RC = 4 * N + 2 + K;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, failures = 0;
  bit m_loaded = 0;
  logic [15:0] m_jobs = '0;
  attn_sched_if #(.N(N), .K(K)) bus ();
  attn_sched #(.N(N), .K(K), .WLOAD_CYCLES(WL)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag, input bit ready);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_dp"}, 32'(bus.do_process), 0);
    chk({tag, "_wle"}, 32'(bus.weight_load_enable), 0);
    chk({tag, "_rv"}, 32'(bus.result_valid), 0);
    chk({tag, "_cnt"}, 32'(bus.cycle_cnt), 0);
    chk({tag, "_lanes"}, 32'(bus.q_lane_en), 0);
    chk({tag, "_caps"}, 32'({bus.qk_cap, bus.exp_cap, bus.out_cap}), 0);
    chk({tag, "_ready"}, 32'(bus.start_ready), 32'(ready));
    chk({tag, "_jobs"}, 32'(bus.jobs_done), 32'(m_jobs));
  endtask

  // one job: t counts cycles after the handshake edge; the expected phase of each cycle
  // follows from the load length (0 or WL) and the run length RC+1
  task automatic run_job(input bit reload, input int abort_at, input int reset_at);
    int wl, r;
    bit is_load, is_run, is_done, stop;
    logic [N-1:0] lanes;
    wl = (reload || !m_loaded) ? WL : 0;
    @(negedge clk);
    chk("pre_ready", 32'(bus.start_ready), 1);
    bus.start_valid = 1'b1;
    bus.reload_weights = reload;
    stop = 0;
    for (int t = 1; !stop; t++) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
      bus.reload_weights = 1'b0;
      is_load = t <= wl;
      r = t - wl - 1;
      is_run = !is_load && r <= RC;
      is_done = r == RC + 1;
      if (is_done) m_jobs++;
      if (is_run) m_loaded = 1;
      for (int j = 0; j < N; j++) lanes[j] = is_run && r >= j && r < j + N;
      chk("wle", 32'(bus.weight_load_enable), 32'(is_load));
      chk("do_process", 32'(bus.do_process), 32'(is_run));
      chk("result_valid", 32'(bus.result_valid), 32'(is_done));
      chk("busy", 32'(bus.busy), 32'(is_load || is_run || is_done));
      chk("start_ready", 32'(bus.start_ready), 32'(!(is_load || is_run || is_done)));
      chk("cycle_cnt", 32'(bus.cycle_cnt), is_run ? 32'(r) : 0);
      chk("q_lane_en", 32'(bus.q_lane_en), 32'(lanes));
      chk("qk_cap", 32'(bus.qk_cap), 32'(is_run && r >= N + 1 && r <= 3 * N - 1));
      chk("exp_cap", 32'(bus.exp_cap), 32'(is_run && r >= N + 1 + K && r <= 3 * N - 1 + K));
      chk("out_cap", 32'(bus.out_cap), 32'(is_run && r >= 2 * N + 2 + K && r <= 4 * N + K));
      chk("jobs_done", 32'(bus.jobs_done), 32'(m_jobs));
      if (!(is_load || is_run || is_done)) stop = 1;
      else if (t == abort_at) begin
        bus.abort = 1'b1;
        if (is_load) m_loaded = 0;
        @(negedge clk);
        chk_idle("abort", 0);
        bus.abort = 1'b0;
        #1 chk("abort_release_ready", 32'(bus.start_ready), 1);
        stop = 1;
      end else if (t == reset_at) begin
        #2 reset = 1'b1;
        m_loaded = 0;
        m_jobs = '0;
        #1 chk_idle("midreset", 1);
        reset = 1'b0;
        stop = 1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab, len;
    bit rl;
    bus.start_valid = 1'b0;
    bus.reload_weights = 1'b0;
    bus.abort = 1'b0;
    #2 chk_idle("reset", 1);
    #20 reset = 1'b0;
    run_job(0, -1, -1);
    run_job(0, -1, -1);
    run_job(0, 11, -1);
    run_job(0, -1, -1);
    run_job(1, 2, -1);
    run_job(0, -1, -1);
    run_job(0, RC + 2, -1);
    @(negedge clk);
    bus.abort = 1'b1;
    bus.start_valid = 1'b1;
    #1 chk("idle_abort_ready", 32'(bus.start_ready), 0);
    @(negedge clk);
    chk_idle("idle_abort", 0);
    bus.abort = 1'b0;
    bus.start_valid = 1'b0;
    run_job(0, -1, 8);
    run_job(0, -1, -1);
    force dut.jobs_q = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_q;
    m_jobs = 16'hFFFF;
    chk("preset_jobs", 32'(bus.jobs_done), 32'hFFFF);
    run_job(0, -1, -1);
    chk("wrap_jobs", 32'(bus.jobs_done), 0);
    for (int i = 0; i < 25; i++) begin
      rl = 1'($urandom_range(0, 1));
      len = ((rl || !m_loaded) ? WL : 0) + RC + 2;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : -1;
      run_job(rl, ab, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
